// File: rtl/tiny_fpga_pkg.sv
// -----------------------------------------------------------------------------
// tiny_fpga_pkg
// Purpose : shared sizes and configuration-field layout for the tiny FPGA
//           fabric, plus a helper that packs one cell's configuration word.
// Ports   : none (package).
// -----------------------------------------------------------------------------
package tiny_fpga_pkg;

   localparam int NUM_CELLS  = 8;
   localparam int CELL_BITS  = 33;
   localparam int CHAIN_LEN  = 272;
   localparam int OE_BASE    = 264;
   localparam int OE_BITS    = 8;

   // Field offsets inside one cell's configuration word
   localparam int LUT_LSB    = 0;
   localparam int LUT_W      = 16;
   localparam int SEL0_LSB   = 16;
   localparam int SEL1_LSB   = 20;
   localparam int SEL2_LSB   = 24;
   localparam int SEL3_LSB   = 28;
   localparam int SEL_W      = 4;
   localparam int REGOUT_BIT = 32;

   // Pack LUT, the four source selects and the output-register flag
   function automatic logic [CELL_BITS-1:0] cell_cfg(
      input logic [LUT_W-1:0] lut,
      input logic [SEL_W-1:0] sel0,
      input logic [SEL_W-1:0] sel1,
      input logic [SEL_W-1:0] sel2,
      input logic [SEL_W-1:0] sel3,
      input logic             reg_out
   );
      cell_cfg = {reg_out, sel3, sel2, sel1, sel0, lut};
   endfunction

endpackage

// File: rtl/tiny_fpga_if.sv
// -----------------------------------------------------------------------------
// tiny_fpga_if
// Purpose : bundles the fabric's pin-level bus (dedicated inputs, dedicated
//           outputs, bidirectional pin in/out/enable) so a driver and the
//           fabric can be wired through one handle.
// Signals : ui_in[7:0]   dedicated inputs (progClk, progRst, progEn, progDataIn)
//           uo_out[7:0]  dedicated outputs ([0] progDataOut)
//           uio_in[7:0]  fabric inputs
//           uio_out[7:0] cell outputs
//           uio_oe[7:0]  pin output enables
// Modports: master drives inputs and observes outputs, slave is the fabric.
// -----------------------------------------------------------------------------
interface tiny_fpga_if;

   logic [7:0] ui_in;
   logic [7:0] uo_out;
   logic [7:0] uio_in;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   modport master (
      output ui_in,
      output uio_in,
      input  uo_out,
      input  uio_out,
      input  uio_oe
   );

   modport slave (
      input  ui_in,
      input  uio_in,
      output uo_out,
      output uio_out,
      output uio_oe
   );

endinterface

// File: rtl/tiny_fpga_cell.sv
// -----------------------------------------------------------------------------
// tiny_fpga_cell
// Purpose : one logic cell: four 16:1 source muxes feeding a LUT4, a q flop
//           that follows the LUT unless held, and an output mux choosing
//           the LUT (combinational) or q (registered).
// Ports   : clk       fabric clock
//           prog_rst  synchronous active-high clear of q
//           hold      freeze q (configuration in progress)
//           cfg       cell configuration word
//           src       16 candidate sources: [7:0] pins, [15:8] cell q values
//           q         registered LUT value (feedback source for other cells)
//           cell_out  cell output
// -----------------------------------------------------------------------------
module tiny_fpga_cell
   import tiny_fpga_pkg::*;
(
   input  logic                 clk,
   input  logic                 prog_rst,
   input  logic                 hold,
   input  logic [CELL_BITS-1:0] cfg,
   input  logic [15:0]          src,
   output logic                 q,
   output logic                 cell_out
);

   logic [LUT_W-1:0] lut_tab_s;
   logic [3:0]       idx_s;
   logic             lut_s;
   logic             q_d;
   logic             q_q;

   // Source selection, LUT lookup, next q and output mux
   always_comb begin
      lut_tab_s = cfg[LUT_LSB +: LUT_W];
      idx_s     = {src[cfg[SEL3_LSB +: SEL_W]],
                   src[cfg[SEL2_LSB +: SEL_W]],
                   src[cfg[SEL1_LSB +: SEL_W]],
                   src[cfg[SEL0_LSB +: SEL_W]]};
      lut_s     = lut_tab_s[idx_s];
      if (hold) begin
         q_d = q_q;
      end else begin
         q_d = lut_s;
      end
      // Feedback sources are only q values, so this path never loops
      if (cfg[REGOUT_BIT]) begin
         cell_out = q_q;
      end else begin
         cell_out = lut_s;
      end
   end

   // Cell state register with synchronous clear
   always_ff @(posedge clk) begin
      if (prog_rst) begin
         q_q <= 1'b0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/tt_um_riceshelley_tiny_fpga.sv
// -----------------------------------------------------------------------------
// tt_um_riceshelley_tiny_fpga
// Purpose : tiny FPGA fabric of 8 LUT4 cells configured through a 272-bit
//           serial chain (8 x 33 cell bits, then 8 pin output enables).
//           The programming clock is treated as data and sampled on clk.
// Ports   : clk      fabric clock
//           rst_n    harness pin, unused
//           ena      harness enable, unused
//           ui_in    [0] progClk, [1] progRst (sync, active-high),
//                    [2] progEn, [3] progDataIn, [7:4] unused
//           uo_out   [0] progDataOut (chain bit 0), [7:1] zero
//           uio_in   fabric inputs
//           uio_out  cell k output on bit k
//           uio_oe   output enables from the top of the chain
// -----------------------------------------------------------------------------
module tt_um_riceshelley_tiny_fpga #(
   parameter int NUM_CELLS = 8,
   parameter int CELL_BITS = 33
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   import tiny_fpga_pkg::*;

   logic                 prog_rst_s;
   logic                 shift_s;
   logic [15:0]          src_s;
   logic [NUM_CELLS-1:0] q_all_s;
   logic [NUM_CELLS-1:0] cell_out_s;
   logic                 unused_s;

   logic clk_meta_d, clk_meta_q, clk_sync_d, clk_sync_q, clk_prev_d, clk_prev_q;
   logic en_meta_d,  en_meta_q,  en_sync_d,  en_sync_q;
   logic din_meta_d, din_meta_q, din_sync_d, din_sync_q;
   logic [CHAIN_LEN-1:0] chain_d;
   logic [CHAIN_LEN-1:0] chain_q;

   assign prog_rst_s = ui_in[1];

   // Synchroniser next-state, progClk rising-edge detect and chain shift
   always_comb begin
      clk_meta_d = ui_in[0];
      clk_sync_d = clk_meta_q;
      clk_prev_d = clk_sync_q;
      en_meta_d  = ui_in[2];
      en_sync_d  = en_meta_q;
      din_meta_d = ui_in[3];
      din_sync_d = din_meta_q;
      // progEn and data travel through the same two stages as progClk,
      // so they are aligned with the detected edge
      shift_s    = clk_sync_q & ~clk_prev_q & en_sync_q;
      if (shift_s) begin
         chain_d = {din_sync_q, chain_q[CHAIN_LEN-1:1]};
      end else begin
         chain_d = chain_q;
      end
   end

   // Programming-side state with synchronous progRst
   always_ff @(posedge clk) begin
      if (prog_rst_s) begin
         clk_meta_q <= 1'b0;
         clk_sync_q <= 1'b0;
         clk_prev_q <= 1'b0;
         en_meta_q  <= 1'b0;
         en_sync_q  <= 1'b0;
         din_meta_q <= 1'b0;
         din_sync_q <= 1'b0;
         chain_q    <= '0;
      end else begin
         clk_meta_q <= clk_meta_d;
         clk_sync_q <= clk_sync_d;
         clk_prev_q <= clk_prev_d;
         en_meta_q  <= en_meta_d;
         en_sync_q  <= en_sync_d;
         din_meta_q <= din_meta_d;
         din_sync_q <= din_sync_d;
         chain_q    <= chain_d;
      end
   end

   // Select indices 0-7 pick pins, 8-15 pick cell q values
   assign src_s = {q_all_s, uio_in};

   for (genvar k = 0; k < NUM_CELLS; k++) begin : g_cell
      tiny_fpga_cell u_cell (
         .clk      (clk),
         .prog_rst (prog_rst_s),
         .hold     (en_sync_q),
         .cfg      (chain_q[k*CELL_BITS +: CELL_BITS]),
         .src      (src_s),
         .q        (q_all_s[k]),
         .cell_out (cell_out_s[k])
      );
   end

   assign uio_out  = cell_out_s;
   assign uio_oe   = chain_q[OE_BASE +: OE_BITS];
   assign uo_out   = {7'b000_0000, chain_q[0]};

   // Harness pins with no function in this design
   assign unused_s = &{1'b0, rst_n, ena, ui_in[7:4]};

endmodule

// File: tb/tb_tt_um_riceshelley_tiny_fpga.sv
// -----------------------------------------------------------------------------
// tb_tt_um_riceshelley_tiny_fpga
// Purpose : directed self-checking bench for the tiny FPGA: reset values,
//           pin passthrough, AND gate, registered toggle with hold,
//           chain readback and reset in the middle of shifting.
// -----------------------------------------------------------------------------
module tb_tt_um_riceshelley_tiny_fpga;

   import tiny_fpga_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   logic ena;

   int err_cnt = 0;
   int chk_cnt = 0;

   logic [271:0] cfg_v;
   logic [271:0] rb_v;
   logic [271:0] pat_v;

   tiny_fpga_if bus ();

   always #5 clk = ~clk;

   tt_um_riceshelley_tiny_fpga #(
      .NUM_CELLS (8),
      .CELL_BITS (33)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (bus.ui_in),
      .uo_out  (bus.uo_out),
      .uio_in  (bus.uio_in),
      .uio_out (bus.uio_out),
      .uio_oe  (bus.uio_oe)
   );

   task automatic check_val(input string tag, input logic [271:0] act,
                            input logic [271:0] exp);
      chk_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.ui_in = 8'h02;
      tick(2);
      bus.ui_in = 8'h00;
   endtask

   // One progClk pulse, each phase long enough to cross the synchroniser
   task automatic shift_bit(input logic b);
      bus.ui_in[3] = b;
      bus.ui_in[2] = 1'b1;
      bus.ui_in[0] = 1'b0;
      tick(3);
      bus.ui_in[0] = 1'b1;
      tick(3);
      bus.ui_in[0] = 1'b0;
   endtask

   // Bit 0 goes first; progEn then drops and settles through the synchroniser
   task automatic load_chain(input logic [271:0] v);
      for (int i = 0; i < 272; i++) begin
         shift_bit(v[i]);
      end
      bus.ui_in[2] = 1'b0;
      tick(3);
   endtask

   initial begin
      rst_n      = 1'b1;
      ena        = 1'b1;
      bus.ui_in  = 8'h02;
      bus.uio_in = 8'h00;

      // Reset values
      tick(2);
      check_val("rst_uo_out",  bus.uo_out,  8'h00);
      check_val("rst_uio_out", bus.uio_out, 8'h00);
      check_val("rst_uio_oe",  bus.uio_oe,  8'h00);
      bus.ui_in = 8'h00;

      // Passthrough: every cell copies uio_in[k]
      do_reset();
      cfg_v = '0;
      for (int k = 0; k < 8; k++) begin
         cfg_v[k*33 +: 33] = cell_cfg(16'hAAAA, 4'(k), 4'd0, 4'd0, 4'd0, 1'b0);
      end
      cfg_v[271:264] = 8'hFF;
      load_chain(cfg_v);
      check_val("pass_uio_oe", bus.uio_oe, 8'hFF);
      check_val("pass_uo_out", bus.uo_out, 8'h00);
      bus.uio_in = 8'h5A; #1;
      check_val("pass_5a", bus.uio_out, 8'h5A);
      bus.uio_in = 8'hA5; #1;
      check_val("pass_a5", bus.uio_out, 8'hA5);
      bus.uio_in = 8'h81; #1;
      check_val("pass_81", bus.uio_out, 8'h81);

      // AND gate on cell 0 from uio_in[1:0]
      do_reset();
      cfg_v = '0;
      cfg_v[32:0] = cell_cfg(16'h8888, 4'd0, 4'd1, 4'd0, 4'd0, 1'b0);
      load_chain(cfg_v);
      check_val("and_uio_oe", bus.uio_oe, 8'h00);
      bus.uio_in = 8'hFC; #1;
      check_val("and_fc", bus.uio_out, 8'h00);
      bus.uio_in = 8'h01; #1;
      check_val("and_01", bus.uio_out, 8'h00);
      bus.uio_in = 8'h02; #1;
      check_val("and_02", bus.uio_out, 8'h00);
      bus.uio_in = 8'h03; #1;
      check_val("and_03", bus.uio_out, 8'h01);
      bus.uio_in = 8'hF3; #1;
      check_val("and_f3", bus.uio_out, 8'h01);

      // Toggle: cell 0 inverts its own q, registered output
      bus.uio_in = 8'h00;
      do_reset();
      cfg_v = '0;
      cfg_v[32:0] = cell_cfg(16'h5555, 4'd8, 4'd0, 4'd0, 4'd0, 1'b1);
      load_chain(cfg_v);
      check_val("tog_0", bus.uio_out, 8'h01);
      tick(1);
      check_val("tog_1", bus.uio_out, 8'h00);
      tick(1);
      check_val("tog_2", bus.uio_out, 8'h01);
      tick(1);
      check_val("tog_3", bus.uio_out, 8'h00);
      // progEn=1 without progClk: two more toggles in flight, then frozen
      bus.ui_in[2] = 1'b1;
      tick(3);
      check_val("tog_hold_a", bus.uio_out, 8'h00);
      tick(3);
      check_val("tog_hold_b", bus.uio_out, 8'h00);
      tick(1);
      check_val("tog_hold_c", bus.uio_out, 8'h00);

      // Readback: pattern in, zeros in, pattern out first bit first
      do_reset();
      pat_v = {17{16'hC35A}};
      for (int i = 0; i < 272; i++) begin
         shift_bit(pat_v[i]);
      end
      check_val("rb_uio_oe", bus.uio_oe, 8'hC3);
      check_val("rb_first",  bus.uo_out, 8'h00);
      rb_v = '0;
      for (int j = 0; j < 272; j++) begin
         rb_v[j] = bus.uo_out[0];
         shift_bit(1'b0);
      end
      check_val("rb_stream", rb_v, {17{16'hC35A}});
      check_val("rb_drain_oe", bus.uio_oe, 8'h00);
      check_val("rb_drain_uo", bus.uo_out, 8'h00);

      // Reset after 100 shifts of ones
      do_reset();
      for (int i = 0; i < 100; i++) begin
         shift_bit(1'b1);
      end
      check_val("mid_pre_oe", bus.uio_oe, 8'hFF);
      bus.ui_in = 8'h0F;
      tick(2);
      bus.ui_in = 8'h00;
      tick(3);
      check_val("mid_uio_oe",  bus.uio_oe,  8'h00);
      check_val("mid_uo_out",  bus.uo_out,  8'h00);
      check_val("mid_uio_out", bus.uio_out, 8'h00);
      rb_v = '1;
      for (int j = 0; j < 272; j++) begin
         rb_v[j] = bus.uo_out[0];
         shift_bit(1'b0);
      end
      check_val("mid_chain_zero", rb_v, 272'h0);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/tt_um_riceshelley_tiny_fpga.md
TT_UM_RICESHELLEY_TINY_FPGA -- requirements
Module: tt_um_riceshelley_tiny_fpga

Interface
REQ-001 SHALL have parameter NUM_CELLS, default 8, number of logic cells.
REQ-002 SHALL have parameter CELL_BITS, default 33, configuration bits per cell.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have reset ui_in[1] (progRst), input, synchronous, active-high; it is the only reset.
REQ-005 SHALL have port rst_n, input, 1 bit: harness pin, unused.
REQ-006 SHALL have port ena, input, 1 bit: harness enable, unused.
REQ-007 SHALL have port ui_in, input, 8 bits: [0] progClk, [2] progEn, [3] progDataIn, [7:4] unused.
REQ-008 SHALL have port uo_out, output, 8 bits: [0] progDataOut, [7:1] constant 0.
REQ-009 SHALL have port uio_in, input, 8 bits: fabric inputs.
REQ-010 SHALL have port uio_out, output, 8 bits: uio_out[k] = output of cell k.
REQ-011 SHALL have port uio_oe, output, 8 bits: driven from configuration bits.

Function
REQ-012 SHALL treat progClk as data: a 2-flop synchroniser on clk plus rising-edge detection.
REQ-013 SHALL synchronise progEn and progDataIn through the same 2-flop stage, aligned with progClk.
REQ-014 SHALL hold a 272-bit configuration chain: 8 cells x 33 bits, then 8 uio_oe bits.
REQ-015 SHALL place cell k at bits [33k+32:33k] and uio_oe at chain bits [271:264].
REQ-016 SHALL shift the chain one bit on each detected progClk rising edge while synchronised progEn=1.
- The shift moves toward bit 0; progDataIn enters bit 271.
- This is LSB-first loading: the first bit shifted ends in bit 0 after 272 shifts.
REQ-017 SHALL drive progDataOut = chain bit 0 (registered), enabling chain readback/daisy-chaining.
REQ-018 SHALL leave the chain unchanged when progEn=0 or when no progClk edge is detected.
REQ-019 SHALL decode each cell's fields as follows:
- [15:0] LUT truth table.
- [19:16] sel0, [23:20] sel1, [27:24] sel2, [31:28] sel3.
- [32] regOut.
REQ-020 SHALL decode selects by source index: 0-7 = uio_in[0..7]; 8-15 = registered value q of cells 0-7.
REQ-021 SHALL compute lut = LUT[{in3,in2,in1,in0}], where inN is the source chosen by selN.
REQ-022 SHALL update each cell's q <= lut on every clk edge while synchronised progEn=0, and hold q while progEn=1.
REQ-023 SHALL drive cell output = regOut ? q : lut.
- Feedback goes only through q, so no combinational loops.
REQ-024 SHALL make uio_in-to-uio_out combinational when regOut=0.

Reset
REQ-025 SHALL, on progRst=1 at a clk edge, clear the chain, all q, the synchronisers and the edge detector to 0.
REQ-026 SHALL give progRst priority over a simultaneous shift or q update.
REQ-027 SHALL produce these values after reset: uo_out=0x00, uio_out=0x00, uio_oe=0x00.

Structure
REQ-028 SHALL put NUM_CELLS, CELL_BITS, CHAIN_LEN=272, OE_BASE=264 and the field offsets in package tiny_fpga_pkg.
REQ-029 SHALL implement one sub-module, tiny_fpga_cell (LUT4, four 16:1 muxes, q flop), instantiated 8 times.

Verification
REQ-030 SHALL cover reset: assert progRst for 2 cycles -> uo_out=0x00, uio_out=0x00, uio_oe=0x00.
REQ-031 SHALL cover a passthrough:
- Stimulus: load all cells with LUT=0xAAAA, sel0=k, regOut=0, oe=0xFF.
- Response: uio_in=0x5A gives uio_out=0x5A, and uio_oe=0xFF.
REQ-032 SHALL cover an AND gate:
- Stimulus: cell 0 with LUT=0x8888, sel0=0, sel1=1.
- Response: uio_in[1:0]=11 gives uio_out[0]=1; any other value gives 0.
REQ-033 SHALL cover a toggle:
- Stimulus: cell 0 with LUT=0x5555, sel0=8, regOut=1, progEn=0.
- Response: uio_out[0] toggles every clk.
- Response: with progEn=1, it holds.
REQ-034 SHALL cover readback:
- Stimulus: shift 272 bits of a pattern, then 272 more zeros.
- Response: progDataOut returns the original pattern bit-for-bit, first bit first.
REQ-035 SHALL cover reset mid-shift: assert progRst after 100 shifts -> chain all 0 and progDataOut=0.
